// File: rtl/dpram_ultrasonic_if.sv
// Port-2 bus of the shared dual-port RAM.
// The master drives address, write data and strobes; the RAM returns read data.
interface dpram_ultrasonic_if;
    logic [7:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        rd;
    logic        wr;

    modport master (
        output addr,
        output d_out,
        output rd,
        output wr,
        input  d_in
    );

    modport slave (
        input  addr,
        input  d_out,
        input  rd,
        input  wr,
        output d_in
    );
endinterface

// File: rtl/dpram_ultrasonic_core.sv
// HC-SR04 sequencer driven through a RAM mailbox on port 2.
// Polls CMD, triggers, times the echo, then writes DIST, COUNT and STATUS.
module dpram_ultrasonic_core #(
    parameter int         CLKS_PER_US = 50,
    parameter int         TRIG_US     = 10,
    parameter int         TIMEOUT_US  = 30000,
    parameter logic [7:0] ADDR_BASE   = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    dpram_ultrasonic_if.master bus,
    input  logic               echo,
    output logic               trig
);
    typedef enum logic [3:0] {
        POLL,
        CHECK,
        CLRCMD,
        BUSY,
        TRIG,
        WAIT_HI,
        MEASURE,
        WRDIST,
        WRCNT,
        WRSTAT
    } state_t;

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_US - 1);
    localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] TMO_MAX   = 16'(TIMEOUT_US);

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   us;
    logic [15:0]   count;
    logic          tmo;
    logic          echo_m;
    logic          echo_s;
    logic          unused_ok;

    assign tick      = (presc == PRE_LAST);
    assign unused_ok = ^bus.d_in[15:1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    // Each bus cycle is set up on the edge entering the state that owns it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= POLL;
            trig      <= 1'b0;
            bus.rd    <= 1'b0;
            bus.wr    <= 1'b0;
            bus.addr  <= 8'h00;
            bus.d_out <= 16'h0000;
            presc     <= '0;
            us        <= 16'h0000;
            count     <= 16'h0000;
            tmo       <= 1'b0;
        end else begin
            bus.rd <= 1'b0;
            bus.wr <= 1'b0;
            presc  <= tick ? '0 : presc + 1'b1;
            unique case (state)
                POLL: begin
                    if (bus.rd) begin
                        state <= CHECK;
                    end else begin
                        bus.rd   <= 1'b1;
                        bus.addr <= ADDR_BASE;
                    end
                end
                CHECK: begin
                    if (bus.d_in[0]) begin
                        state     <= CLRCMD;
                        bus.wr    <= 1'b1;
                        bus.addr  <= ADDR_BASE;
                        bus.d_out <= 16'h0000;
                    end else begin
                        state    <= POLL;
                        bus.rd   <= 1'b1;
                        bus.addr <= ADDR_BASE;
                    end
                end
                CLRCMD: begin
                    state     <= BUSY;
                    bus.wr    <= 1'b1;
                    bus.addr  <= ADDR_BASE + 8'd1;
                    bus.d_out <= 16'h0001;
                end
                BUSY: begin
                    state <= TRIG;
                    trig  <= 1'b1;
                    presc <= '0;
                    us    <= 16'h0000;
                    tmo   <= 1'b0;
                end
                TRIG: begin
                    if (tick) begin
                        if (us == TRIG_LAST) begin
                            state <= WAIT_HI;
                            trig  <= 1'b0;
                            presc <= '0;
                            us    <= 16'h0000;
                        end else begin
                            us <= us + 16'd1;
                        end
                    end
                end
                WAIT_HI: begin
                    if (echo_s) begin
                        state <= MEASURE;
                        presc <= '0;
                        us    <= 16'h0000;
                    end else if (tick && us == TMO_LAST) begin
                        state     <= WRDIST;
                        tmo       <= 1'b1;
                        bus.wr    <= 1'b1;
                        bus.addr  <= ADDR_BASE + 8'd2;
                        bus.d_out <= 16'hFFFF;
                    end else if (tick) begin
                        us <= us + 16'd1;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state     <= WRDIST;
                        bus.wr    <= 1'b1;
                        bus.addr  <= ADDR_BASE + 8'd2;
                        bus.d_out <= us;
                    end else if (us >= TMO_MAX) begin
                        state     <= WRDIST;
                        tmo       <= 1'b1;
                        bus.wr    <= 1'b1;
                        bus.addr  <= ADDR_BASE + 8'd2;
                        bus.d_out <= 16'hFFFF;
                    end else if (tick && us != 16'hFFFF) begin
                        us <= us + 16'd1;
                    end
                end
                WRDIST: begin
                    state     <= WRCNT;
                    count     <= count + 16'd1;
                    bus.wr    <= 1'b1;
                    bus.addr  <= ADDR_BASE + 8'd3;
                    bus.d_out <= count + 16'd1;
                end
                WRCNT: begin
                    state     <= WRSTAT;
                    bus.wr    <= 1'b1;
                    bus.addr  <= ADDR_BASE + 8'd1;
                    bus.d_out <= {13'b0, tmo, 2'b10};
                end
                WRSTAT: begin
                    state    <= POLL;
                    bus.rd   <= 1'b1;
                    bus.addr <= ADDR_BASE;
                end
                default: state <= POLL;
            endcase
        end
    end
endmodule

// File: tb/tb_dpram_ultrasonic_core.sv
// Directed bench for dpram_ultrasonic_core with a port-2 RAM model.
// Timings are scaled down (10 clk/us, 1000 us timeout) to keep runs short.
module tb_dpram_ultrasonic_core;
    localparam int CPU = 10;
    localparam int TUS = 10;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic echo = 1'b0;
    logic trig;

    dpram_ultrasonic_if bus();

    logic [15:0] mem [256];
    logic [15:0] rdata;
    logic        j1_we = 1'b0;
    logic [7:0]  j1_addr = 8'h00;
    logic [15:0] j1_data = 16'h0000;

    int          wr_n = 0;
    int          rd_n = 0;
    int          trig_n = 0;
    logic [7:0]  log_a [64];
    logic [15:0] log_d [64];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign bus.d_in = rdata;

    dpram_ultrasonic_core #(
        .CLKS_PER_US(CPU),
        .TRIG_US(TUS),
        .TIMEOUT_US(TMO),
        .ADDR_BASE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .echo(echo),
        .trig(trig)
    );

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            rdata <= 16'h0000;
        end else begin
            if (j1_we) mem[j1_addr] <= j1_data;
            if (bus.wr) mem[bus.addr] <= bus.d_out;
            if (bus.rd) rdata <= mem[bus.addr];
        end
        if (bus.wr && wr_n < 64) begin
            log_a[wr_n] <= bus.addr;
            log_d[wr_n] <= bus.d_out;
        end
        if (bus.wr) wr_n <= wr_n + 1;
        if (bus.rd) rd_n <= rd_n + 1;
        if (trig) trig_n <= trig_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input int idx,
                             input logic [7:0] a, input logic [15:0] d);
        check({tag, "_addr"}, log_a[idx], a);
        check({tag, "_data"}, log_d[idx], d);
    endtask

    task automatic expect_dist(input string tag, input int idx, input int exp);
        int d;
        d = int'(log_d[idx]);
        check({tag, "_addr"}, log_a[idx], 8'h02);
        check({tag, "_dist"}, (d + 1 >= exp && d <= exp + 1) ? exp : d, exp);
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_wait"}, wr_n >= n, 1);
    endtask

    task automatic wait_trig(input string tag, input logic lvl, input int budget);
        int k = 0;
        while (trig !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_trig"}, trig, lvl);
    endtask

    task automatic j1_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        j1_we   = 1'b1;
        j1_addr = a;
        j1_data = d;
        @(negedge clk);
        j1_we = 1'b0;
    endtask

    task automatic echo_pulse(input int gap_us, input int w_us);
        repeat (gap_us * CPU) @(negedge clk);
        echo = 1'b1;
        repeat (w_us * CPU) @(negedge clk);
        echo = 1'b0;
    endtask

    initial begin
        int base;
        int r0;
        int t0;
        int snap;

        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_wr", bus.wr, 0);
        check("rst_rd", bus.rd, 0);
        check("rst_addr", bus.addr, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("first_rd", bus.rd, 1);
        check("first_rd_addr", bus.addr, 8'h00);
        r0 = rd_n;
        repeat (20) @(negedge clk);
        check("poll_rate", rd_n - r0, 10);
        check("poll_no_wr", wr_n, 0);

        // Normal measurement: 100 us gap, 580 us echo.
        base = wr_n;
        j1_write(8'h00, 16'h0001);
        wait_wr("n_start", base + 2, 100);
        expect_wr("n_clr", base, 8'h00, 16'h0000);
        expect_wr("n_busy", base + 1, 8'h01, 16'h0001);
        wait_trig("n_hi", 1'b1, 50);
        t0 = trig_n;
        wait_trig("n_lo", 1'b0, 400);
        check("n_trig_width", trig_n - t0, TUS * CPU);
        echo_pulse(100, 580);
        wait_wr("n_done", base + 5, 200);
        expect_dist("n_dist", base + 2, 580);
        expect_wr("n_cnt", base + 3, 8'h03, 16'h0001);
        expect_wr("n_stat", base + 4, 8'h01, 16'h0002);
        check("n_mem_stat", mem[1], 16'h0002);

        // No echo: rise wait times out.
        base = wr_n;
        j1_write(8'h00, 16'h0001);
        wait_wr("ne", base + 5, TMO * CPU + 2000);
        expect_wr("ne_dist", base + 2, 8'h02, 16'hFFFF);
        expect_wr("ne_cnt", base + 3, 8'h03, 16'h0002);
        expect_wr("ne_stat", base + 4, 8'h01, 16'h0006);

        // Stuck echo: high before start, width times out.
        echo = 1'b1;
        base = wr_n;
        j1_write(8'h00, 16'h0001);
        wait_wr("se", base + 5, TMO * CPU + 2000);
        expect_wr("se_dist", base + 2, 8'h02, 16'hFFFF);
        expect_wr("se_cnt", base + 3, 8'h03, 16'h0003);
        expect_wr("se_stat", base + 4, 8'h01, 16'h0006);
        echo = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back: new start written during MEASURE.
        base = wr_n;
        j1_write(8'h00, 16'h0001);
        wait_trig("bb_hi", 1'b1, 100);
        wait_trig("bb_lo", 1'b0, 400);
        repeat (50 * CPU) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        j1_write(8'h00, 16'h0001);
        repeat (200 * CPU - 102) @(negedge clk);
        echo = 1'b0;
        wait_wr("bb1", base + 5, 200);
        expect_dist("bb1_dist", base + 2, 200);
        expect_wr("bb1_cnt", base + 3, 8'h03, 16'h0004);
        expect_wr("bb1_stat", base + 4, 8'h01, 16'h0002);
        wait_wr("bb2_start", base + 7, 100);
        expect_wr("bb2_clr", base + 5, 8'h00, 16'h0000);
        expect_wr("bb2_busy", base + 6, 8'h01, 16'h0001);
        wait_trig("bb2_hi", 1'b1, 100);
        wait_trig("bb2_lo", 1'b0, 400);
        echo_pulse(20, 50);
        wait_wr("bb2", base + 10, 200);
        expect_dist("bb2_dist", base + 7, 50);
        expect_wr("bb2_cnt", base + 8, 8'h03, 16'h0005);
        expect_wr("bb2_stat", base + 9, 8'h01, 16'h0002);

        // COUNT wrap from a preloaded shadow.
        repeat (10) @(negedge clk);
        force dut.count = 16'hFFFF;
        @(negedge clk);
        release dut.count;
        base = wr_n;
        j1_write(8'h00, 16'h0001);
        wait_trig("wr_hi", 1'b1, 100);
        wait_trig("wr_lo", 1'b0, 400);
        echo_pulse(10, 30);
        wait_wr("wrap", base + 5, 200);
        expect_dist("wrap_dist", base + 2, 30);
        expect_wr("wrap_cnt", base + 3, 8'h03, 16'h0000);
        expect_wr("wrap_stat", base + 4, 8'h01, 16'h0002);
        check("wrap_mem_cnt", mem[3], 16'h0000);

        // Reset during TRIG aborts with no mailbox writes.
        base = wr_n;
        j1_write(8'h00, 16'h0001);
        wait_trig("mr_hi", 1'b1, 100);
        repeat (20) @(negedge clk);
        snap = wr_n;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mr_trig_drop", trig, 0);
        check("mr_wr", bus.wr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        r0 = rd_n;
        t0 = trig_n;
        repeat (2000) @(negedge clk);
        check("mr_no_wr", wr_n, snap);
        check("mr_poll", rd_n - r0, 1000);
        check("mr_no_trig", trig_n, t0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dpram_ultrasonic_core.md
Name: dpram_ultrasonic_core

Overview:
Peripheral-side master on port 2 of the shared dual-port RAM. It polls a command word written by the J1 over port 1 and runs one HC-SR04 measurement: a trigger pulse, then timing of the echo width. It writes the distance, the status and a measurement count back into the RAM mailbox. The J1 never touches the sensor pins directly.

Parameters:
CLKS_PER_US, 50, clock cycles per microsecond (50 MHz clk)
TRIG_US, 10, trigger pulse width in microseconds
TIMEOUT_US, 30000, maximum microseconds for echo-rise wait and for echo-high time
ADDR_BASE, 8'h00, mailbox base address on port 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
addr  out  8  port-2 RAM address
d_in  in  16  port-2 RAM read data (RAM d_out_2)
d_out  out  16  port-2 RAM write data (RAM d_in_2)
rd  out  1  port-2 read strobe
wr  out  1  port-2 write strobe
echo  in  1  sensor echo, asynchronous
trig  out  1  sensor trigger

Behaviour:
- Mailbox (offset from ADDR_BASE):
  - +0 CMD: bit0 = start.
  - +1 STATUS: bit0 busy, bit1 done, bit2 timeout.
  - +2 DIST: echo width in µs.
  - +3 COUNT: completed measurements, wraps 0xFFFF->0.
- RAM read timing: data is valid on d_in exactly 1 clk after the cycle in which rd=1.
- Strobes: rd and wr are single-cycle and never asserted together. addr and d_out are registered and valid in the same cycle as the strobe.
- Echo synchronizer: echo passes through a 2-FF synchronizer. All echo decisions use the synchronized value.
- Microsecond tick: a prescaler counts 0..CLKS_PER_US-1. A tick fires on wrap. The prescaler is cleared on entry to TRIG, WAIT_HI and MEASURE.
- Reset (rst=0 at a clk edge):
  - State goes to POLL.
  - trig=0, rd=0, wr=0, addr=0, d_out=0.
  - Internal counters and COUNT shadow are cleared.
  - Applies mid-measurement too: trig drops on the next edge and no partial write is issued.
- FSM:
  - POLL: rd=1, addr=+0 -> CHECK.
  - CHECK: if d_in[0]=1 -> CLRCMD, else -> POLL. Polling rate is therefore one read per 2 clk.
  - CLRCMD: wr=1, addr=+0, d_out=0 -> BUSY.
  - BUSY: wr=1, addr=+1, d_out=16'h0001 -> TRIG.
  - TRIG: trig=1 for TRIG_US ticks -> WAIT_HI, trig=0.
  - WAIT_HI:
    - Synchronized echo=1 -> MEASURE, with the µs counter cleared.
    - If TIMEOUT_US ticks elapse first -> timeout path.
  - MEASURE:
    - The µs counter increments per tick and saturates at 0xFFFF.
    - Synchronized echo=0 -> WRDIST with dist=counter.
    - If the counter reaches TIMEOUT_US while echo is still high -> timeout path.
  - Timeout path: dist=16'hFFFF, timeout flag set -> WRDIST.
  - WRDIST: wr=1, addr=+2, d_out=dist -> WRCNT.
  - WRCNT: wr=1, addr=+3, d_out=count+1. The shadow is updated -> WRSTAT.
  - WRSTAT: wr=1, addr=+1, d_out={13'b0, timeout, 1'b1, 1'b0} -> POLL.
- CMD handling: CMD is cleared before the measurement starts, so a start written by the J1 during a measurement is seen on the next POLL and begins a new measurement back-to-back.
- STATUS write order: STATUS is always written last, so done=1 guarantees DIST and COUNT are already valid.
- Port conflicts: a simultaneous J1 write to the same address is resolved by the RAM. This block has no arbitration.
- Echo state at start: if echo is already high when entering WAIT_HI, measurement starts immediately and the width includes the stale high time. This is accepted behaviour.

Test Plan:
- Reset: hold rst=0 for 3 clk, then release -> trig=0, wr=0, 8'h00 on addr; first rd at +0 on the next clk, then a rd every 2 clk while CMD=0.
- Normal measurement:
  - Stimulus: CMD=1; echo rises 100 µs after trig falls, high 580 µs.
  - Required: writes in order +0<=0, +1<=0x0001.
  - Required: trig high for exactly 500 clk.
  - Required: then +2<=580 (±1), +3<=0x0001, +1<=0x0002.
- No echo: CMD=1, echo stays 0 -> after 30000 µs, +2<=0xFFFF, +1<=0x0006.
- Stuck echo: echo held high -> +2<=0xFFFF after 30000 µs of MEASURE, timeout bit set.
- Back-to-back: J1 writes CMD=1 during MEASURE -> second measurement follows; COUNT reads 2, then wraps 0xFFFF->0 when preloaded.
- Reset mid-TRIG: rst=0 while trig=1 -> trig=0 on the next edge, no wr to +2/+3/+1, polling resumes.
